// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with HI/LO result registers.
// Multiplies by shift-add and divides by restoring division, one step per
// cycle on operand magnitudes, applying signs when the result is written.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dz
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             is_div;     // op[1]: divide rather than multiply
    logic             neg_res;    // product / quotient must be negated
    logic             neg_rem;    // remainder takes the dividend's sign
    logic [WIDTH-1:0] a_raw;      // original dividend, returned on divide-by-zero
    logic [WIDTH-1:0] oper;       // multiplicand or divisor magnitude
    logic [WIDTH-1:0] acc_hi;     // partial product high half / remainder
    logic [WIDTH-1:0] acc_lo;     // multiplier shifting out / quotient shifting in

    // Operand magnitudes and sign flags at acceptance
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;

    // One iteration step and the signed-corrected final result
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [WIDTH:0]     sum;
    logic [WIDTH+1:0]   trial;
    logic [2*WIDTH-1:0] prod, prod_neg;
    logic [WIDTH-1:0]   res_hi, res_lo;
    logic               res_dz;

    // Magnitudes of the incoming operands; unsigned ops never negate
    always_comb begin
        a_neg = ~op[0] & a[WIDTH-1];
        b_neg = ~op[0] & b[WIDTH-1];
        mag_a = a_neg ? -a : a;
        mag_b = b_neg ? -b : b;
    end

    // Single multiply or divide iteration plus result formatting
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        sum      = '0;
        trial    = '0;
        step_hi  = acc_hi;
        step_lo  = acc_lo;
        if (!is_div) begin
            // Add multiplicand when the multiplier LSB is set, then shift right.
            sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, oper} : '0);
            step_hi = sum[WIDTH:1];
            step_lo = {sum[0], acc_lo[WIDTH-1:1]};
        end else begin
            // Shift next dividend bit into the remainder and try subtracting;
            // the extra top bit of trial is the borrow.
            trial = {1'b0, acc_hi, acc_lo[WIDTH-1]} - {2'b00, oper};
            if (!trial[WIDTH+1]) begin
                step_hi = trial[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
                step_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end

        prod     = {step_hi, step_lo};
        prod_neg = -prod;
        res_dz   = is_div && (oper == '0);
        if (!is_div) begin
            {res_hi, res_lo} = neg_res ? prod_neg : prod;
        end else if (res_dz) begin
            res_hi = a_raw;
            res_lo = '1;
        end else begin
            // Most-negative / -1 yields magnitude 2^(WIDTH-1), whose negation
            // is the most-negative value again, so no special case is needed.
            res_hi = neg_rem ? -step_hi : step_hi;
            res_lo = neg_res ? -step_lo : step_lo;
        end
    end

    // Control FSM, datapath registers and HI/LO with direct writes
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            dz      <= 1'b0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            a_raw   <= '0;
            oper    <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        cnt     <= CW'(WIDTH);
                        is_div  <= op[1];
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        a_raw   <= a;
                        acc_hi  <= '0;
                        oper    <= op[1] ? mag_b : mag_a;
                        acc_lo  <= op[1] ? mag_a : mag_b;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        hi    <= res_hi;
                        lo    <= res_lo;
                        dz    <= res_dz;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vector table plus hand-written sequences for
// back-to-back issue, ignored mid-run requests/writes and reset abort.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         hi_we, lo_we;
    logic [W-1:0] wdata;
    logic         busy, done, dz;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    typedef struct {
        string        name;
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
        logic         exp_dz;
    } vec_t;

    vec_t vecs[10];

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo),
        .dz    (dz)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present an op for one clock edge (driven and released on negedges).
    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        // Scramble inputs to prove operands were latched at acceptance.
        a     = 32'hDEAD_BEEF;
        b     = 32'h0BAD_F00D;
        op    = ~o;
    endtask

    // Wait (bounded) until done is seen at a negedge; counts busy samples.
    task automatic wait_done(output int busy_cycles, output bit seen);
        busy_cycles = 0;
        seen        = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cycles++;
            @(negedge clk);
        end
    endtask

    initial begin
        int bc;
        bit seen;
        int done_cnt;

        vecs[0] = '{"mult_neg3x5",    MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
        vecs[1] = '{"multu_max",      MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[2] = '{"div_neg7_2",     DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3] = '{"div_min_m1",     DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[4] = '{"divu_by0",       DIVU,  32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
        vecs[5] = '{"divu_100_7",     DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0};
        vecs[6] = '{"div_7_neg2",     DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        vecs[7] = '{"mult_min_min",   MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[8] = '{"div_neg7_by0",   DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
        vecs[9] = '{"multu_shift",    MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0};

        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hi",   64'(hi),   64'd0);
        check("reset_lo",   64'(lo),   64'd0);
        check("reset_dz",   64'(dz),   64'd0);

        // Table-driven vectors
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(bc, seen);
            check({vecs[i].name, "_done"}, 64'(seen), 64'd1);
            check({vecs[i].name, "_busy_cycles"}, 64'(bc), 64'd32);
            check({vecs[i].name, "_hi"}, 64'(hi), 64'(vecs[i].exp_hi));
            check({vecs[i].name, "_lo"}, 64'(lo), 64'(vecs[i].exp_lo));
            check({vecs[i].name, "_dz"}, 64'(dz), 64'(vecs[i].exp_dz));
            @(negedge clk);
            check({vecs[i].name, "_done_pulse"}, 64'(done), 64'd0);
        end

        // Divide by zero, then MULTU issued in the DONE cycle (no bubble)
        issue(DIVU, 32'h64, 32'h0);
        wait_done(bc, seen);
        check("b2b_first_done", 64'(seen), 64'd1);
        check("b2b_first_dz", 64'(dz), 64'd1);
        check("b2b_first_lo", 64'(lo), 64'hFFFF_FFFF);
        issue(MULTU, 32'd2, 32'd3);
        check("b2b_no_bubble_busy", 64'(busy), 64'd1);
        check("b2b_no_bubble_done", 64'(done), 64'd0);
        wait_done(bc, seen);
        check("b2b_second_done", 64'(seen), 64'd1);
        check("b2b_second_busy_cycles", 64'(bc), 64'd32);
        check("b2b_second_lo", 64'(lo), 64'd6);
        check("b2b_second_hi", 64'(hi), 64'd0);
        check("b2b_second_dz", 64'(dz), 64'd0);
        // Write in the DONE cycle overwrites the fresh result
        lo_we = 1'b1; wdata = 32'h0000_AAAA;
        @(negedge clk);
        lo_we = 1'b0;
        check("done_cycle_lo_write", 64'(lo), 64'h0000_AAAA);

        // Write coinciding with accepted start lands, then result overwrites it
        hi_we = 1'b1; wdata = 32'h5555_0000;
        issue(MULTU, 32'd3, 32'd4);
        hi_we = 1'b0;
        check("start_write_hi", 64'(hi), 64'h5555_0000);
        // Mid-run start and hi_we are ignored
        repeat (5) @(negedge clk);
        start = 1'b1; op = DIVU; a = 32'd9; b = 32'd2;
        hi_we = 1'b1; wdata = 32'h1234_5678;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        check("run_write_ignored", 64'(hi), 64'h5555_0000);
        wait_done(bc, seen);
        check("midrun_done", 64'(seen), 64'd1);
        check("midrun_hi", 64'(hi), 64'd0);
        check("midrun_lo", 64'(lo), 64'd12);
        @(negedge clk);
        check("midrun_start_ignored_busy", 64'(busy), 64'd0);
        hi_we = 1'b1; wdata = 32'h1234_5678;
        @(negedge clk);
        hi_we = 1'b0;
        check("idle_hi_write", 64'(hi), 64'h1234_5678);
        check("idle_hi_write_lo_kept", 64'(lo), 64'd12);

        // Reset during RUN aborts with no done pulse
        issue(MULT, 32'hFFFF_FFFD, 32'd5);
        repeat (9) @(negedge clk);
        check("pre_reset_busy", 64'(busy), 64'd1);
        rst = 1'b1; start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hFFFF_0000;
        @(negedge clk);
        rst = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        check("abort_dz", 64'(dz), 64'd0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        check("abort_no_done", 64'(done_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
